// File: rtl/prog_loader.sv
// Program loader: streams instruction words into processor RAM, then
// enables the processor for a bounded run window sized by program length.
module prog_loader #(
    parameter int unsigned DRAIN = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        go,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    input  logic        in_last,
    output logic        in_ready,
    output logic [8:0]  addr,
    output logic        wr,
    output logic [31:0] wdata,
    output logic        working,
    output logic [9:0]  count,
    output logic        done,
    output logic        err
);

    localparam int RW = 16;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        GAP,
        RUN,
        DONE,
        ERR
    } state_e;

    state_e        state_q, state_d;
    logic [8:0]    ptr_q, ptr_d;
    logic [9:0]    count_q, count_d;
    logic          wr_q, wr_d;
    logic [8:0]    addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          gap_q, gap_d;
    logic [RW-1:0] run_q, run_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [RW-1:0] run_last;

    // Run window spans count+DRAIN cycles; wide enough not to wrap at 512.
    assign run_last = RW'(count_q) + RW'(DRAIN) - RW'(1);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        wr_d    = 1'b0;
        addr_d  = 9'd0;
        wdata_d = 32'd0;
        gap_d   = gap_q;
        run_d   = run_q;
        done_d  = done_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE, DONE, ERR: begin
                if (go) begin
                    state_d = LOAD;
                    ptr_d   = 9'd0;
                    count_d = 10'd0;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                end
            end
            LOAD: begin
                if (in_valid) begin
                    wr_d    = 1'b1;
                    addr_d  = ptr_q;
                    wdata_d = in_data;
                    ptr_d   = ptr_q + 9'd1;
                    count_d = count_q + 10'd1;
                    if (in_last) begin
                        state_d = GAP;
                        gap_d   = 1'b0;
                    end else if (ptr_q == 9'd511) begin
                        state_d = ERR;
                        err_d   = 1'b1;
                    end
                end
            end
            // First GAP cycle overlaps the final write; second is the quiet one.
            GAP: begin
                if (gap_q) begin
                    state_d = RUN;
                    run_d   = '0;
                end else begin
                    gap_d = 1'b1;
                end
            end
            RUN: begin
                if (run_q == run_last) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    run_d = run_q + RW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ptr_q   <= 9'd0;
            count_q <= 10'd0;
            wr_q    <= 1'b0;
            addr_q  <= 9'd0;
            wdata_q <= 32'd0;
            gap_q   <= 1'b0;
            run_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            gap_q   <= gap_d;
            run_q   <= run_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign in_ready = (state_q == LOAD);
    assign working  = (state_q == RUN);
    assign addr     = addr_q;
    assign wr       = wr_q;
    assign wdata    = wdata_q;
    assign count    = count_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: normal, throttled, single-word,
// overflow and reset-abort loads with hand-computed expectations.
module tb_prog_loader;

    logic        clock;
    logic        reset_n;
    logic        go;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_last;
    logic        in_ready;
    logic [8:0]  addr;
    logic        wr;
    logic [31:0] wdata;
    logic        working;
    logic [9:0]  count;
    logic        done;
    logic        err;

    int tests;
    int fails;
    logic [31:0] prog [12];

    prog_loader #(.DRAIN(4)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .go      (go),
        .in_valid(in_valid),
        .in_data (in_data),
        .in_last (in_last),
        .in_ready(in_ready),
        .addr    (addr),
        .wr      (wr),
        .wdata   (wdata),
        .working (working),
        .count   (count),
        .done    (done),
        .err     (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_go();
        go = 1'b1;
        tick();
        go = 1'b0;
        chk("go_in_ready", in_ready, 1);
        chk("go_count", count, 0);
        chk("go_done", done, 0);
        chk("go_err", err, 0);
    endtask

    task automatic xfer(input logic [31:0] d, input logic last,
                        input int exp_addr);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        tick();
        chk("wr", wr, 1);
        chk("addr", addr, exp_addr);
        chk("wdata", wdata, d);
        chk("count", count, exp_addr + 1);
    endtask

    task automatic run_window(input int exp_len, input int exp_cnt);
        int n;
        int bad;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 32'd0;
        tick();
        chk("gap_wr", wr, 0);
        chk("gap_addr", addr, 0);
        chk("gap_working", working, 0);
        n   = 0;
        bad = 0;
        tick();
        while (working && n < 2000) begin
            n++;
            if (wr !== 1'b0 || addr !== 9'd0) bad++;
            tick();
        end
        chk("run_len", n, exp_len);
        chk("run_quiet", bad, 0);
        chk("done", done, 1);
        chk("done_count", count, exp_cnt);
        chk("done_working", working, 0);
    endtask

    task automatic load_prog(input bit toggle);
        for (int i = 0; i < 12; i++) begin
            xfer(prog[i], (i == 11), i);
            if (toggle && i != 11) begin
                in_valid = 1'b0;
                in_data  = 32'hFFFF_FFFF;
                tick();
                chk("idle_wr", wr, 0);
                chk("idle_wdata", wdata, 0);
            end
        end
        run_window(16, 12);
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        reset_n  = 1'b0;
        go       = 1'b0;
        in_valid = 1'b0;
        in_data  = 32'd0;
        in_last  = 1'b0;
        for (int i = 0; i < 8; i++)
            prog[i] = 32'h10F0_0080 + 32'h0001_0001 * i;
        prog[8]  = 32'h2001_0000;
        prog[9]  = 32'h2123_0000;
        prog[10] = 32'h2245_0000;
        prog[11] = 32'h2367_0000;

        tick();
        tick();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_addr", addr, 0);
        chk("rst_wr", wr, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_working", working, 0);
        chk("rst_count", count, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);

        reset_n  = 1'b1;
        in_valid = 1'b1;
        in_last  = 1'b1;
        in_data  = 32'h1234_5678;
        tick();
        tick();
        chk("idle_no_ready", in_ready, 0);
        chk("idle_no_wr", wr, 0);
        chk("idle_no_count", count, 0);
        in_valid = 1'b0;
        in_last  = 1'b0;

        pulse_go();
        load_prog(1'b0);

        pulse_go();
        load_prog(1'b1);

        pulse_go();
        in_valid = 1'b0;
        in_last  = 1'b1;
        tick();
        chk("last_novalid_wr", wr, 0);
        chk("last_novalid_ready", in_ready, 1);
        xfer(32'hDEAD_BEEF, 1'b1, 0);
        run_window(5, 1);

        pulse_go();
        for (int i = 0; i < 512; i++)
            xfer(32'hA500_0000 + i, 1'b0, i);
        chk("ovf_err", err, 1);
        chk("ovf_ready", in_ready, 0);
        chk("ovf_count", count, 512);
        in_data = 32'hBAD0_0513;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ovf_no_wr", wr, 0);
            chk("ovf_no_work", working, 0);
        end
        chk("ovf_count_hold", count, 512);
        chk("ovf_err_hold", err, 1);
        in_valid = 1'b0;
        pulse_go();
        xfer(32'h0000_0013, 1'b1, 0);
        run_window(5, 1);

        pulse_go();
        for (int i = 0; i < 12; i++) begin
            if (i == 2) go = 1'b1;
            xfer(prog[i], (i == 11), i);
            go = 1'b0;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        tick();
        chk("abort_gap_work", working, 0);
        tick();
        tick();
        tick();
        chk("abort_run3", working, 1);
        reset_n = 1'b0;
        tick();
        chk("abort_working", working, 0);
        chk("abort_wr", wr, 0);
        chk("abort_addr", addr, 0);
        chk("abort_wdata", wdata, 0);
        chk("abort_count", count, 0);
        chk("abort_done", done, 0);
        chk("abort_err", err, 0);
        chk("abort_ready", in_ready, 0);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("post_rst_work", working, 0);
            chk("post_rst_wr", wr, 0);
        end
        chk("post_rst_done", done, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
